// File: rtl/execute_pipe_if.sv
// execute_pipe_if: operand/handshake bundle between the ID/EX register, the execute stage and the memory stage.
interface execute_pipe_if #(parameter int N = 64);
    logic         valid_in;
    logic         ready_out;
    logic         AluSrc;
    logic [3:0]   AluControl;
    logic [N-1:0] PC_E;
    logic [N-1:0] signImm_E;
    logic [N-1:0] readData1_E;
    logic [N-1:0] readData2_E;
    logic         valid_out;
    logic         ready_in;
    logic [N-1:0] PCBranch_M;
    logic [N-1:0] aluResult_M;
    logic [N-1:0] writeData_M;
    logic         zero_M;
    modport slave (
        input  valid_in, AluSrc, AluControl, PC_E, signImm_E, readData1_E, readData2_E, ready_in,
        output ready_out, valid_out, PCBranch_M, aluResult_M, writeData_M, zero_M
    );
    modport master (
        output valid_in, AluSrc, AluControl, PC_E, signImm_E, readData1_E, readData2_E, ready_in,
        input  ready_out, valid_out, PCBranch_M, aluResult_M, writeData_M, zero_M
    );
endinterface

// File: rtl/execute_pipe.sv
// execute_pipe: LEGv8 execute stage with valid/ready handshake and a one-entry EX/MEM output register.
// Define EXECUTE_PIPE_MUL_EN to build in the iterative shift-add multiplier (AluControl 1000).
module execute_pipe #(
    parameter int N        = 64,
    parameter int BR_SHIFT = 1
) (
    input  logic          clk,
    input  logic          reset,
    execute_pipe_if.slave bus
);
    logic [N-1:0] op_b, alu_y, pcb, mul_res, mul_pcb, mul_wd;
    logic [N-1:0] alu_q, alu_d, pcb_q, pcb_d, wd_q, wd_d;
    logic         valid_q, valid_d, zero_q, zero_d;
    logic         idle, is_mul, mul_done, drain_ok, accept, load;

    assign drain_ok = !valid_q || bus.ready_in;
    assign accept   = bus.valid_in && idle && drain_ok;

    always_comb begin
        op_b  = bus.AluSrc ? bus.signImm_E : bus.readData2_E;
        pcb   = bus.PC_E + (bus.signImm_E << BR_SHIFT);
        alu_y = bus.AluControl == 4'b0000 ? bus.readData1_E & op_b :
                bus.AluControl == 4'b0001 ? bus.readData1_E | op_b :
                bus.AluControl == 4'b0010 ? bus.readData1_E + op_b :
                bus.AluControl == 4'b0110 ? bus.readData1_E - op_b :
                bus.AluControl == 4'b0111 ? op_b :
                bus.AluControl == 4'b1100 ? ~(bus.readData1_E | op_b) : '0;
    end

`ifdef EXECUTE_PIPE_MUL_EN
    typedef enum logic {IDLE, MUL} state_t;
    localparam int CW = $clog2(N);
    state_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, lpcb_q, lpcb_d, lwd_q, lwd_d;
    logic         at_end;

    assign idle     = state_q == IDLE;
    assign is_mul   = bus.AluControl == 4'b1000;
    assign at_end   = cnt_q == CW'(N - 1);
    assign mul_res  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_done = state_q == MUL && at_end && drain_ok;
    assign mul_pcb  = lpcb_q;
    assign mul_wd   = lwd_q;

    // The final step's sum goes straight to the output register; a stalled finish holds at N-1.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        lpcb_d   = lpcb_q;
        lwd_d    = lwd_q;
        if (accept && is_mul) begin
            state_d  = MUL;
            cnt_d    = '0;
            mcand_d  = bus.readData1_E;
            mplier_d = op_b;
            acc_d    = '0;
            lpcb_d   = pcb;
            lwd_d    = bus.readData2_E;
        end else if (state_q == MUL && !at_end) begin
            cnt_d    = cnt_q + 1'b1;
            acc_d    = mul_res;
            mplier_d = mplier_q >> 1;
            mcand_d  = mcand_q << 1;
        end else if (mul_done) begin
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            lpcb_q   <= '0;
            lwd_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            lpcb_q   <= lpcb_d;
            lwd_q    <= lwd_d;
        end
    end
`else
    assign idle     = 1'b1;
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
    assign mul_res  = '0;
    assign mul_pcb  = '0;
    assign mul_wd   = '0;
`endif

    always_comb begin
        load    = (accept && !is_mul) || mul_done;
        valid_d = load || (valid_q && !bus.ready_in);
        alu_d   = load ? (mul_done ? mul_res : alu_y) : alu_q;
        pcb_d   = load ? (mul_done ? mul_pcb : pcb) : pcb_q;
        wd_d    = load ? (mul_done ? mul_wd : bus.readData2_E) : wd_q;
        zero_d  = load ? (alu_d == '0) : zero_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            alu_q   <= '0;
            pcb_q   <= '0;
            wd_q    <= '0;
            zero_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            alu_q   <= alu_d;
            pcb_q   <= pcb_d;
            wd_q    <= wd_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.ready_out   = idle && drain_ok;
    assign bus.valid_out   = valid_q;
    assign bus.aluResult_M = alu_q;
    assign bus.PCBranch_M  = pcb_q;
    assign bus.writeData_M = wd_q;
    assign bus.zero_M      = zero_q;
endmodule

// File: tb/tb_execute_pipe.sv
// tb_execute_pipe: directed self-checking bench for execute_pipe (N=64, BR_SHIFT=1).
module tb_execute_pipe;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    execute_pipe_if #(.N(64)) bus ();
    execute_pipe #(.N(64), .BR_SHIFT(1)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [3:0] ctrl, input logic src,
                         input logic [63:0] pc, input logic [63:0] imm,
                         input logic [63:0] r1, input logic [63:0] r2);
        bus.valid_in    = v;
        bus.AluControl  = ctrl;
        bus.AluSrc      = src;
        bus.PC_E        = pc;
        bus.signImm_E   = imm;
        bus.readData1_E = r1;
        bus.readData2_E = r2;
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.ready_in = 1'b1;
        drive(1'b1, 4'b0010, 1'b0, 64'h100, 64'h4, 64'h1, 64'h2);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({bus.valid_out, bus.zero_M} !== 2'b00 || bus.aluResult_M !== '0 ||
                bus.PCBranch_M !== '0 || bus.writeData_M !== '0) begin
                failures++;
                $display("FAIL reset_hold cycle %0d: valid=%b zero=%b alu=%h pcb=%h wd=%h, required all 0",
                         i, bus.valid_out, bus.zero_M, bus.aluResult_M, bus.PCBranch_M, bus.writeData_M);
            end
        end
        reset = 1'b0;
        bus.valid_in = 1'b0;
        step();
        checks++;
        if (bus.ready_out !== 1'b1 || bus.valid_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: ready_out=%b valid_out=%b, required 1/0", bus.ready_out, bus.valid_out);
        end
    endtask

    task automatic test_add_imm;
        drive(1'b1, 4'b0010, 1'b1, 64'h100, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'h77);
        step();
        bus.valid_in = 1'b0;
        checks++;
        if (bus.valid_out !== 1'b1 || bus.aluResult_M !== 64'd2 || bus.zero_M !== 1'b0 ||
            bus.PCBranch_M !== 64'hFA || bus.writeData_M !== 64'h77) begin
            failures++;
            $display("FAIL add_imm: valid=%b alu=%h zero=%b pcb=%h wd=%h, required 1/2/0/fa/77",
                     bus.valid_out, bus.aluResult_M, bus.zero_M, bus.PCBranch_M, bus.writeData_M);
        end
    endtask

    task automatic test_sub_zero;
        drive(1'b1, 4'b0110, 1'b0, 64'h0, 64'h0, 64'h1234, 64'h1234);
        step();
        bus.valid_in = 1'b0;
        checks++;
        if (bus.valid_out !== 1'b1 || bus.aluResult_M !== '0 || bus.zero_M !== 1'b1 ||
            bus.writeData_M !== 64'h1234) begin
            failures++;
            $display("FAIL sub_zero: valid=%b alu=%h zero=%b wd=%h, required 1/0/1/1234",
                     bus.valid_out, bus.aluResult_M, bus.zero_M, bus.writeData_M);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  ctrl [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011, 4'b1111};
        logic [63:0] expv [8] = '{64'h00F0, 64'hFFF0, 64'h100E0, 64'hE100, 64'h0FF0,
                                  64'hFFFF_FFFF_FFFF_000F, 64'h0, 64'h0};
        bus.ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, ctrl[i], 1'b0, 64'h20, 64'(i), 64'hF0F0, 64'h0FF0);
            checks++;
            if (bus.ready_out !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready op%0d: ready_out=%b, required 1", i, bus.ready_out);
            end
            step();
            checks++;
            if (bus.valid_out !== 1'b1 || bus.aluResult_M !== expv[i] ||
                bus.zero_M !== (expv[i] == 64'h0) || bus.PCBranch_M !== 64'h20 + 64'(2 * i)) begin
                failures++;
                $display("FAIL b2b_op ctrl=%b: valid=%b alu=%h zero=%b pcb=%h, required alu=%h pcb=%h",
                         ctrl[i], bus.valid_out, bus.aluResult_M, bus.zero_M, bus.PCBranch_M,
                         expv[i], 64'h20 + 64'(2 * i));
            end
        end
        bus.valid_in = 1'b0;
        step();
    endtask

    task automatic test_backpressure;
        bus.ready_in = 1'b0;
        drive(1'b1, 4'b0000, 1'b0, 64'h0, 64'h0, 64'hFF, 64'h0F);
        step();
        drive(1'b1, 4'b0001, 1'b0, 64'h0, 64'h0, 64'hF0, 64'h0F);
        checks++;
        if (bus.valid_out !== 1'b1 || bus.aluResult_M !== 64'h0F || bus.ready_out !== 1'b0) begin
            failures++;
            $display("FAIL bp_first: valid=%b alu=%h ready_out=%b, required 1/0f/0",
                     bus.valid_out, bus.aluResult_M, bus.ready_out);
        end
        step();
        checks++;
        if (bus.valid_out !== 1'b1 || bus.aluResult_M !== 64'h0F || bus.writeData_M !== 64'h0F) begin
            failures++;
            $display("FAIL bp_hold: valid=%b alu=%h wd=%h, required 1/0f/0f",
                     bus.valid_out, bus.aluResult_M, bus.writeData_M);
        end
        bus.ready_in = 1'b1;
        #1;
        checks++;
        if (bus.ready_out !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_follow: ready_out=%b, required 1", bus.ready_out);
        end
        step();
        bus.valid_in = 1'b0;
        checks++;
        if (bus.valid_out !== 1'b1 || bus.aluResult_M !== 64'hFF) begin
            failures++;
            $display("FAIL bp_drain_accept: valid=%b alu=%h, required 1/ff", bus.valid_out, bus.aluResult_M);
        end
        step();
        checks++;
        if (bus.valid_out !== 1'b0 || bus.aluResult_M !== 64'hFF) begin
            failures++;
            $display("FAIL bp_drain_only: valid=%b alu=%h, required 0/ff", bus.valid_out, bus.aluResult_M);
        end
    endtask

`ifdef EXECUTE_PIPE_MUL_EN
    task automatic test_mul;
        int n = 0;
        bus.ready_in = 1'b1;
        drive(1'b1, 4'b1000, 1'b0, 64'h10, 64'h4, 64'hFFFF_FFFF, 64'h1_0000_0001);
        step();
        bus.valid_in = 1'b0;
        while (bus.ready_out !== 1'b1 && n < 200) begin
            n++;
            checks++;
            if (bus.valid_out !== 1'b0) begin
                failures++;
                $display("FAIL mul_early_valid at cycle %0d: valid_out=%b, required 0", n, bus.valid_out);
            end
            step();
        end
        checks++;
        if (n != 64) begin
            failures++;
            $display("FAIL mul_latency: ready_out low %0d cycles, required 64", n);
        end
        checks++;
        if (bus.valid_out !== 1'b1 || bus.aluResult_M !== 64'hFFFF_FFFF_FFFF_FFFF || bus.zero_M !== 1'b0 ||
            bus.PCBranch_M !== 64'h18 || bus.writeData_M !== 64'h1_0000_0001) begin
            failures++;
            $display("FAIL mul_result: valid=%b alu=%h zero=%b pcb=%h wd=%h, required 1/ffffffffffffffff/0/18/100000001",
                     bus.valid_out, bus.aluResult_M, bus.zero_M, bus.PCBranch_M, bus.writeData_M);
        end
        step();
    endtask

    task automatic test_reset_mid_op;
        bus.ready_in = 1'b1;
        drive(1'b1, 4'b1000, 1'b1, 64'h0, 64'd3, 64'd7, 64'd0);
        step();
        bus.valid_in = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (bus.valid_out !== 1'b0 || bus.ready_out !== 1'b1) begin
            failures++;
            $display("FAIL mid_mul_reset: valid=%b ready_out=%b, required 0/1", bus.valid_out, bus.ready_out);
        end
        repeat (70) begin
            step();
            checks++;
            if (bus.valid_out !== 1'b0) begin
                failures++;
                $display("FAIL mid_mul_discard: valid_out=%b, required 0", bus.valid_out);
            end
        end
        drive(1'b1, 4'b0010, 1'b0, 64'h0, 64'h0, 64'd1, 64'd2);
        step();
        bus.valid_in = 1'b0;
        checks++;
        if (bus.valid_out !== 1'b1 || bus.aluResult_M !== 64'd3) begin
            failures++;
            $display("FAIL post_reset_add: valid=%b alu=%h, required 1/3", bus.valid_out, bus.aluResult_M);
        end
    endtask
`else
    task automatic test_mul;
        bus.ready_in = 1'b1;
        drive(1'b1, 4'b1000, 1'b0, 64'h10, 64'h4, 64'd5, 64'd7);
        step();
        bus.valid_in = 1'b0;
        checks++;
        if (bus.valid_out !== 1'b1 || bus.aluResult_M !== '0 || bus.zero_M !== 1'b1 ||
            bus.PCBranch_M !== 64'h18 || bus.ready_out !== 1'b1) begin
            failures++;
            $display("FAIL mul_off: valid=%b alu=%h zero=%b pcb=%h ready_out=%b, required 1/0/1/18/1",
                     bus.valid_out, bus.aluResult_M, bus.zero_M, bus.PCBranch_M, bus.ready_out);
        end
        step();
    endtask

    task automatic test_reset_mid_op;
        bus.ready_in = 1'b0;
        drive(1'b1, 4'b0001, 1'b0, 64'h0, 64'h0, 64'h5, 64'h8);
        step();
        bus.valid_in = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.ready_in = 1'b1;
        checks++;
        if (bus.valid_out !== 1'b0 || bus.aluResult_M !== '0 || bus.ready_out !== 1'b1) begin
            failures++;
            $display("FAIL held_reset: valid=%b alu=%h ready_out=%b, required 0/0/1",
                     bus.valid_out, bus.aluResult_M, bus.ready_out);
        end
        drive(1'b1, 4'b0010, 1'b0, 64'h0, 64'h0, 64'd1, 64'd2);
        step();
        bus.valid_in = 1'b0;
        checks++;
        if (bus.valid_out !== 1'b1 || bus.aluResult_M !== 64'd3) begin
            failures++;
            $display("FAIL post_reset_add: valid=%b alu=%h, required 1/3", bus.valid_out, bus.aluResult_M);
        end
    endtask
`endif

    initial begin
        bus.ready_in = 1'b1;
        drive(1'b0, 4'b0, 1'b0, '0, '0, '0, '0);
        @(negedge clk);
        test_reset();
        test_add_imm();
        test_sub_zero();
        test_back_to_back();
        test_backpressure();
        test_mul();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
